barrel_pc_sched: RTL and testbench
==================================

Name: barrel_pc_sched

Overview:
- Fetch-side per-thread PC file and barrel thread scheduler for the multithreaded RV32 pipeline.
- Each cycle it issues one thread's PC to fetch in strict round-robin order.
- It is the receiving end of the execute stage's redirect interface (pc_src_e, pc_target_e, tid_e): it applies taken branches and jumps to the owning thread's PC.
- It also handles thread halt and start requests.

Parameters:
- ADDRESS_WIDTH, 32, PC width.
- NUM_THREADS, 8, hardware thread count; need not be a power of 2; must be >= 3.
- BITS_THREADS, $clog2(NUM_THREADS), thread-id width.
- RESET_PC, 32'h0000_0000, reset PC of thread 0.
- THREAD_PC_STRIDE, 32'h0000_1000, reset PC spacing between threads.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  freeze scheduling and the current thread's PC increment.
- pc_src_e  in  1  redirect valid from execute.
- pc_target_e  in  ADDRESS_WIDTH  redirect target.
- tid_e  in  BITS_THREADS  thread owning the redirect or halt.
- halt_e  in  1  deactivate thread tid_e.
- start_valid  in  1  activate thread start_tid at start_pc.
- start_tid  in  BITS_THREADS  thread to start.
- start_pc  in  ADDRESS_WIDTH  start address.
- pc_f  out  ADDRESS_WIDTH  PC issued to fetch this cycle.
- pc_plus4_f  out  ADDRESS_WIDTH  pc_f + 4.
- tid_f  out  BITS_THREADS  thread issued this cycle.
- fetch_valid_f  out  1  issued slot holds a live instruction.
- active_mask  out  NUM_THREADS  per-thread active bits.

Behaviour:
- Reset (async, rst_n=0):
  - cur_tid=0.
  - pc[t] = RESET_PC + t*THREAD_PC_STRIDE.
  - active = all ones.
  - Outputs while held: pc_f=RESET_PC, pc_plus4_f=RESET_PC+4, tid_f=0, fetch_valid_f=1, active_mask=all ones.
  - Reset mid-operation discards all pending state immediately; no request is remembered.
- Scheduler: cur_tid advances by 1 per cycle when stall_f=0 and wraps from NUM_THREADS-1 to 0. It holds when stall_f=1.
- Inactive threads keep their slot: the slot is issued as a bubble (fetch_valid_f=0). Slot spacing is therefore fixed at NUM_THREADS cycles, which guarantees a thread's redirect (resolved 2 cycles after fetch) lands before its next slot.
- Outputs are combinational from state plus bypass, zero latency:
  - tid_f = cur_tid.
  - pc_f = pc_target_e if (pc_src_e && tid_e==cur_tid), else pc[cur_tid].
  - pc_plus4_f = pc_f + 4, mod 2^ADDRESS_WIDTH (wraps; no overflow flag).
  - fetch_valid_f = active[cur_tid] && !(halt_e && tid_e==cur_tid) && !stall_f.
- PC update for each thread t at the clock edge, priority high to low:
  1. start_valid && start_tid==t: pc[t] <= start_pc, active[t] <= 1.
  2. pc_src_e && tid_e==t: pc[t] <= pc_target_e.
  3. t==cur_tid && !stall_f && active[t]: pc[t] <= pc_f + 4. This uses the bypassed pc_f, so a same-cycle redirect to the current thread yields pc[t] <= pc_target_e + 4.
  4. Otherwise pc[t] holds.
- Active update:
  - halt_e && tid_e==t: active[t] <= 0, unless start for the same t in the same cycle; start wins.
  - A halt and a redirect for the same thread may both apply: active clears and pc takes the target.
- Start targeting cur_tid in the same cycle is not bypassed; it takes effect at that thread's next slot.
- Redirects and starts to an inactive thread still update its PC.
- stall_f does not block redirect, halt or start updates.
- tid_e and start_tid values >= NUM_THREADS are ignored.

Test Plan:
- Reset, NUM_THREADS=4, no stall, 8 cycles:
  - tid_f sequence 0,1,2,3,0,1,2,3.
  - pc_f sequence 0x0,0x1000,0x2000,0x3000,0x4,0x1004,0x2004,0x3004.
  - fetch_valid_f=1 throughout.
- Redirect: pulse pc_src_e=1, tid_e=1, pc_target_e=0x500 while cur_tid=3 → thread 1's next slot shows pc_f=0x500, and the slot after that 0x504.
- Same-slot collision: pc_src_e=1, tid_e=2, target 0x800 while cur_tid=2 → pc_f=0x800, pc_plus4_f=0x804 that cycle; thread 2's next slot shows 0x804.
- Halt/start:
  - halt_e on tid 3 → active_mask=4'b0111; thread 3's slots show fetch_valid_f=0 while tids keep rotating.
  - start_valid tid 3, pc 0x9000 → next thread-3 slot shows pc_f=0x9000, valid=1.
  - Simultaneous halt and start on tid 3 → stays active.
- Stall: hold stall_f=1 for 3 cycles at cur_tid=1 → tid_f and pc_f frozen, fetch_valid_f=0. Release → same PC issued with valid=1, then rotation resumes.
- Async reset asserted mid-cycle at cur_tid=2 with redirect pending → outputs return immediately to tid_f=0, pc_f=RESET_PC; the redirect is lost. Also NUM_THREADS=3 wrap: sequence 0,1,2,0.

Source files
------------

// File: rtl/barrel_pc_sched_if.sv
// barrel_pc_sched_if
//   Bundles the fetch-side scheduler's control inputs and the fetch outputs.
//   master : pipeline side (drives stall/redirect/halt/start, observes fetch).
//   slave  : the scheduler (observes controls, drives pc_f/tid_f/valid/mask).
//   Signals:
//     stall_f, pc_src_e, pc_target_e, tid_e, halt_e,
//     start_valid, start_tid, start_pc                  -> scheduler
//     pc_f, pc_plus4_f, tid_f, fetch_valid_f, active_mask <- scheduler
interface barrel_pc_sched_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 8,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS)
);
    logic                     stall_f;
    logic                     pc_src_e;
    logic [ADDRESS_WIDTH-1:0] pc_target_e;
    logic [BITS_THREADS-1:0]  tid_e;
    logic                     halt_e;
    logic                     start_valid;
    logic [BITS_THREADS-1:0]  start_tid;
    logic [ADDRESS_WIDTH-1:0] start_pc;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
    logic [BITS_THREADS-1:0]  tid_f;
    logic                     fetch_valid_f;
    logic [NUM_THREADS-1:0]   active_mask;

    modport master (
        output stall_f, pc_src_e, pc_target_e, tid_e, halt_e,
               start_valid, start_tid, start_pc,
        input  pc_f, pc_plus4_f, tid_f, fetch_valid_f, active_mask
    );

    modport slave (
        input  stall_f, pc_src_e, pc_target_e, tid_e, halt_e,
               start_valid, start_tid, start_pc,
        output pc_f, pc_plus4_f, tid_f, fetch_valid_f, active_mask
    );
endinterface

// File: rtl/barrel_pc_sched.sv
// barrel_pc_sched
//   Per-thread PC file plus strict round-robin (barrel) thread scheduler for
//   the fetch stage. One thread slot is issued per unstalled cycle; inactive
//   threads keep their slot and issue a bubble, so each thread's slot recurs
//   every NUM_THREADS cycles.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - barrel_pc_sched_if.slave (redirect/halt/start in, fetch out)

// One thread's PC and active bit.
module barrel_pc_thread #(
    parameter int                     AW     = 32,
    parameter logic [AW-1:0]          RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,     // start request targets this thread
    input  logic          i_redir,     // redirect targets this thread
    input  logic          i_halt,      // halt targets this thread
    input  logic          i_issue,     // this thread owns the unstalled slot
    input  logic [AW-1:0] i_start_pc,
    input  logic [AW-1:0] i_target,
    input  logic [AW-1:0] i_pc_next,   // bypassed pc_f + 4
    output logic [AW-1:0] o_pc,
    output logic          o_active
);
    logic [AW-1:0] r_pc;
    logic          r_active;

    // Issue is checked before redirect: when both hit, i_pc_next already
    // carries the bypassed target, so the thread lands on target + 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RST_PC;
            r_active <= 1'b1;
        end else begin
            if (i_start)                  r_pc <= i_start_pc;
            else if (i_issue && r_active) r_pc <= i_pc_next;
            else if (i_redir)             r_pc <= i_target;

            if (i_start)     r_active <= 1'b1;
            else if (i_halt) r_active <= 1'b0;
        end
    end

    assign o_pc     = r_pc;
    assign o_active = r_active;
endmodule

module barrel_pc_sched #(
    parameter int                         ADDRESS_WIDTH    = 32,
    parameter int                         NUM_THREADS      = 8,
    parameter int                         BITS_THREADS     = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC         = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0]   THREAD_PC_STRIDE = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst_n,
    barrel_pc_sched_if.slave bus
);
    localparam logic [BITS_THREADS-1:0] LP_LAST_TID = BITS_THREADS'(NUM_THREADS - 1);

    logic [BITS_THREADS-1:0]                   r_cur_tid;
    logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] w_pc;
    logic [NUM_THREADS-1:0]                    w_active;
    logic                                      w_redir_cur;
    logic                                      w_halt_cur;
    logic [ADDRESS_WIDTH-1:0]                  w_pc_f;
    logic [ADDRESS_WIDTH-1:0]                  w_pc_plus4;

    // Round-robin pointer; explicit wrap so non-power-of-2 counts work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cur_tid <= '0;
        else if (!bus.stall_f)
            r_cur_tid <= (r_cur_tid == LP_LAST_TID) ? '0
                                                    : r_cur_tid + BITS_THREADS'(1);
    end

    // A redirect or halt resolving for the thread in the current slot is
    // bypassed so fetch never issues a stale PC or a dead instruction.
    assign w_redir_cur = bus.pc_src_e && (bus.tid_e == r_cur_tid);
    assign w_halt_cur  = bus.halt_e   && (bus.tid_e == r_cur_tid);
    assign w_pc_f      = w_redir_cur ? bus.pc_target_e : w_pc[r_cur_tid];
    assign w_pc_plus4  = w_pc_f + ADDRESS_WIDTH'(4);

    // Thread ids >= NUM_THREADS never match any g, so they are ignored.
    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        localparam logic [BITS_THREADS-1:0]  LP_TID = BITS_THREADS'(g);
        localparam logic [ADDRESS_WIDTH-1:0] LP_RST =
            RESET_PC + ADDRESS_WIDTH'(g) * THREAD_PC_STRIDE;

        barrel_pc_thread #(
            .AW     (ADDRESS_WIDTH),
            .RST_PC (LP_RST)
        ) u_thr (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_start    (bus.start_valid && (bus.start_tid == LP_TID)),
            .i_redir    (bus.pc_src_e    && (bus.tid_e     == LP_TID)),
            .i_halt     (bus.halt_e      && (bus.tid_e     == LP_TID)),
            .i_issue    (!bus.stall_f    && (r_cur_tid     == LP_TID)),
            .i_start_pc (bus.start_pc),
            .i_target   (bus.pc_target_e),
            .i_pc_next  (w_pc_plus4),
            .o_pc       (w_pc[g]),
            .o_active   (w_active[g])
        );
    end

    assign bus.pc_f          = w_pc_f;
    assign bus.pc_plus4_f    = w_pc_plus4;
    assign bus.tid_f         = r_cur_tid;
    assign bus.fetch_valid_f = w_active[r_cur_tid] && !w_halt_cur && !bus.stall_f;
    assign bus.active_mask   = w_active;
endmodule

// File: tb/tb_barrel_pc_sched.sv
module tb_barrel_pc_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrel_pc_sched_if #(.ADDRESS_WIDTH(32), .NUM_THREADS(4)) if0 ();
    barrel_pc_sched_if #(.ADDRESS_WIDTH(32), .NUM_THREADS(3)) if1 ();

    barrel_pc_sched #(.ADDRESS_WIDTH(32), .NUM_THREADS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    barrel_pc_sched #(.ADDRESS_WIDTH(32), .NUM_THREADS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic [1:0]  tid;
        logic [31:0] pc;
        logic        vld;
        logic [3:0]  mask;
    } exp_t;

    exp_t sbq[$];

    task automatic push(input int dut, input string n, input logic [1:0] tid,
                        input logic [31:0] pc, input logic v, input logic [3:0] m);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.name = n;
        e.tid = tid; e.pc = pc; e.vld = v; e.mask = m;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.stall_f = 0; if0.pc_src_e = 0; if0.pc_target_e = 0; if0.tid_e = 0;
        if0.halt_e = 0; if0.start_valid = 0; if0.start_tid = 0; if0.start_pc = 0;
    endtask

    // Expect on the 4-thread DUT for the current cycle, then advance one cycle.
    task automatic step(input string n, input logic [1:0] tid, input logic [31:0] pc,
                        input logic v, input logic [3:0] m);
        push(0, n, tid, pc, v, m);
        tick();
        idle();
    endtask

    // Monitor: compares every queued expectation due in the current cycle.
    initial begin
        exp_t        e;
        logic [1:0]  a_tid;
        logic [31:0] a_pc, a_pc4;
        logic        a_vld;
        logic [3:0]  a_mask;
        forever begin
            @(negedge clk or chk_ev);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                if (e.dut == 0) begin
                    a_tid = if0.tid_f; a_pc = if0.pc_f; a_pc4 = if0.pc_plus4_f;
                    a_vld = if0.fetch_valid_f; a_mask = if0.active_mask;
                end else begin
                    a_tid = if1.tid_f; a_pc = if1.pc_f; a_pc4 = if1.pc_plus4_f;
                    a_vld = if1.fetch_valid_f; a_mask = {1'b0, if1.active_mask};
                end
                n_cmp++;
                if (e.cyc != cyc || a_tid !== e.tid || a_pc !== e.pc ||
                    a_pc4 !== e.pc + 32'd4 || a_vld !== e.vld || a_mask !== e.mask) begin
                    n_bad++;
                    $display("FAIL %s (dut%0d cyc %0d/%0d): got tid=%0d pc=%h pc4=%h vld=%b mask=%b, want tid=%0d pc=%h pc4=%h vld=%b mask=%b",
                             e.name, e.dut, cyc, e.cyc, a_tid, a_pc, a_pc4, a_vld, a_mask,
                             e.tid, e.pc, e.pc + 32'd4, e.vld, e.mask);
                end
            end
        end
    end

    logic [31:0] p4 [8] = '{32'h0, 32'h1000, 32'h2000, 32'h3000,
                            32'h4, 32'h1004, 32'h2004, 32'h3004};
    logic [31:0] p3 [4] = '{32'h0, 32'h1000, 32'h2000, 32'h4};

    initial begin
        idle();
        if1.stall_f = 0; if1.pc_src_e = 0; if1.pc_target_e = 0; if1.tid_e = 0;
        if1.halt_e = 0; if1.start_valid = 0; if1.start_tid = 0; if1.start_pc = 0;

        // Held in reset
        tick();
        push(0, "rst_hold", 0, 32'h0, 1, 4'hF);
        push(1, "rst_hold3", 0, 32'h0, 1, 4'h7);
        tick();
        rst_n = 1'b1;

        // Free-running rotation; 3-thread instance checks wrap 0,1,2,0
        for (int i = 0; i < 8; i++) begin
            if (i < 4) push(1, "wrap3", 2'(i % 3), p3[i], 1, 4'h7);
            step("rotate", 2'(i % 4), p4[i], 1, 4'hF);
        end

        // Redirect thread 1 while thread 3 holds the slot
        step("rd_c0", 0, 32'h8, 1, 4'hF);
        step("rd_c1", 1, 32'h1008, 1, 4'hF);
        step("rd_c2", 2, 32'h2008, 1, 4'hF);
        if0.pc_src_e = 1; if0.tid_e = 1; if0.pc_target_e = 32'h500;
        step("rd_issue", 3, 32'h3008, 1, 4'hF);
        step("rd_c0b", 0, 32'hC, 1, 4'hF);
        step("rd_land", 1, 32'h500, 1, 4'hF);
        step("rd_c2b", 2, 32'h200C, 1, 4'hF);
        step("rd_c3b", 3, 32'h300C, 1, 4'hF);
        step("rd_c0c", 0, 32'h10, 1, 4'hF);
        step("rd_next", 1, 32'h504, 1, 4'hF);

        // Same-slot collision on thread 2
        if0.pc_src_e = 1; if0.tid_e = 2; if0.pc_target_e = 32'h800;
        step("coll_bypass", 2, 32'h800, 1, 4'hF);
        step("coll_c3", 3, 32'h3010, 1, 4'hF);
        step("coll_c0", 0, 32'h14, 1, 4'hF);
        step("coll_c1", 1, 32'h508, 1, 4'hF);
        step("coll_next", 2, 32'h804, 1, 4'hF);

        // Halt thread 3 in its own slot
        if0.halt_e = 1; if0.tid_e = 3;
        step("halt_slot", 3, 32'h3014, 0, 4'hF);
        step("halt_c0", 0, 32'h18, 1, 4'h7);
        step("halt_c1", 1, 32'h50C, 1, 4'h7);
        step("halt_c2", 2, 32'h808, 1, 4'h7);
        step("halt_bubble", 3, 32'h3018, 0, 4'h7);
        step("halt_c0b", 0, 32'h1C, 1, 4'h7);
        step("halt_c1b", 1, 32'h510, 1, 4'h7);
        step("halt_c2b", 2, 32'h80C, 1, 4'h7);
        // Start thread 3 in its own slot: not bypassed
        if0.start_valid = 1; if0.start_tid = 3; if0.start_pc = 32'h9000;
        step("start_nobyp", 3, 32'h3018, 0, 4'h7);
        step("start_c0", 0, 32'h20, 1, 4'hF);
        step("start_c1", 1, 32'h514, 1, 4'hF);
        step("start_c2", 2, 32'h810, 1, 4'hF);
        step("start_land", 3, 32'h9000, 1, 4'hF);
        // Simultaneous halt and start on thread 3: start wins
        if0.halt_e = 1; if0.tid_e = 3;
        if0.start_valid = 1; if0.start_tid = 3; if0.start_pc = 32'hA000;
        step("hs_c0", 0, 32'h24, 1, 4'hF);
        step("hs_c1", 1, 32'h518, 1, 4'hF);
        step("hs_c2", 2, 32'h814, 1, 4'hF);
        step("hs_land", 3, 32'hA000, 1, 4'hF);
        step("hs_c0b", 0, 32'h28, 1, 4'hF);

        // Stall three cycles on thread 1
        for (int i = 0; i < 3; i++) begin
            if0.stall_f = 1;
            step("stall_hold", 1, 32'h51C, 0, 4'hF);
        end
        step("stall_release", 1, 32'h51C, 1, 4'hF);
        step("stall_c2", 2, 32'h818, 1, 4'hF);
        step("stall_c3", 3, 32'hA004, 1, 4'hF);
        step("pre_c0", 0, 32'h2C, 1, 4'hF);
        step("pre_c1", 1, 32'h520, 1, 4'hF);

        // Async reset mid-cycle while a redirect for the current thread pends
        if0.pc_src_e = 1; if0.tid_e = 2; if0.pc_target_e = 32'hBEEF0;
        push(0, "pre_rst_bypass", 2, 32'hBEEF0, 1, 4'hF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(0, "async_rst", 0, 32'h0, 1, 4'hF);
        -> chk_ev;
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        step("post_c0", 0, 32'h0, 1, 4'hF);
        step("post_c1", 1, 32'h1000, 1, 4'hF);
        step("post_lost", 2, 32'h2000, 1, 4'hF);
        step("post_c3", 3, 32'h3000, 1, 4'hF);
        tick();

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unchecked: %0d expectations left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
